calc_cmd_sequencer: RTL and testbench

//  Initiator side of the combinational 4-bit calculator interface (a, b, oper -> out).
//  - Accepts operand/opcode commands over a valid/ready handshake and queues them.
//  - Issues one command at a time to the calculator and captures its 8-bit result.
//  - Screens invalid operations and returns results in order over a second valid/ready handshake.

---
 rtl/calc_cmd_sequencer.sv | 153 +++++++++++++++
 tb/tb_calc_cmd_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_sequencer.sv
// Command sequencer for the combinational 4-bit calculator: queues commands, issues one at a time,
// screens invalid ops and returns in-order responses. Optional golden checker under CALC_SEQ_CHECK_EN.
module calc_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OPW        = 4,
  parameter int unsigned RESW       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OPW-1:0]  cmd_a,
  input  logic [OPW-1:0]  cmd_b,
  input  logic [2:0]      cmd_oper,
  output logic [OPW-1:0]  calc_a,
  output logic [OPW-1:0]  calc_b,
  output logic [2:0]      calc_oper,
  input  logic [RESW-1:0] calc_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [RESW-1:0] rsp_data,
  output logic            rsp_err,
  output logic [2:0]      rsp_oper
`ifdef CALC_SEQ_CHECK_EN
  ,
  output logic            chk_mismatch
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = 2 * OPW + 3;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [EW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;
  logic [1:0]      r_state;
  logic [OPW-1:0]  r_calc_a;
  logic [OPW-1:0]  r_calc_b;
  logic [2:0]      r_calc_oper;
  logic            r_rsp_valid;
  logic [RESW-1:0] r_rsp_data;
  logic            r_rsp_err;
  logic [2:0]      r_rsp_oper;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_err;
  logic [EW-1:0]   w_head;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = cmd_valid && !w_full;
  assign w_pop   = (r_state == ST_IDLE) && !w_empty;
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  assign w_err = (((r_calc_oper == 3'b011) || (r_calc_oper == 3'b100)) && (r_calc_b == '0))
               || (r_calc_oper[2:1] == 2'b11);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {cmd_a, cmd_b, cmd_oper};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_state     <= ST_IDLE;
      r_calc_a    <= '0;
      r_calc_b    <= '0;
      r_calc_oper <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_oper  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            {r_calc_a, r_calc_b, r_calc_oper} <= w_head;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= w_err;
          r_rsp_data  <= w_err ? '0 : calc_out;
          r_rsp_oper  <= r_calc_oper;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef CALC_SEQ_CHECK_EN
  logic [RESW-1:0] w_a_ext;
  logic [RESW-1:0] w_b_ext;
  logic [RESW-1:0] w_golden;
  logic            r_chk_mismatch;

  assign w_a_ext = {{(RESW-OPW){1'b0}}, r_calc_a};
  assign w_b_ext = {{(RESW-OPW){1'b0}}, r_calc_b};

  always_comb begin
    w_golden = '0;
    case (r_calc_oper)
      3'b000: w_golden = w_a_ext + w_b_ext;
      3'b001: w_golden = w_a_ext - w_b_ext;
      3'b010: w_golden = w_a_ext * w_b_ext;
      3'b011: if (w_b_ext != '0) w_golden = w_a_ext / w_b_ext;
      3'b100: if (w_b_ext != '0) w_golden = w_a_ext % w_b_ext;
      3'b101: w_golden = ~w_a_ext;
      default: w_golden = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chk_mismatch <= 1'b0;
    end else if ((r_state == ST_ISSUE) && !w_err && (w_golden != calc_out)) begin
      r_chk_mismatch <= 1'b1;
    end
  end

  assign chk_mismatch = r_chk_mismatch;
`endif

  assign cmd_ready = !w_full;
  assign calc_a    = r_calc_a;
  assign calc_b    = r_calc_b;
  assign calc_oper = r_calc_oper;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign rsp_oper  = r_rsp_oper;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed bench for calc_cmd_sequencer with a behavioural calculator model on calc_*/calc_out.
module tb_calc_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_oper;
  logic [3:0] calc_a;
  logic [3:0] calc_b;
  logic [2:0] calc_oper;
  logic [7:0] calc_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [2:0] rsp_oper;
  logic       force_zero = 1'b0;
`ifdef CALC_SEQ_CHECK_EN
  logic       chk_mismatch;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_cmd_sequencer #(.FIFO_DEPTH(4), .OPW(4), .RESW(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_oper(cmd_oper),
    .calc_a(calc_a), .calc_b(calc_b), .calc_oper(calc_oper), .calc_out(calc_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_oper(rsp_oper)
`ifdef CALC_SEQ_CHECK_EN
    , .chk_mismatch(chk_mismatch)
`endif
  );

  // Calculator model; invalid ops drive junk that the sequencer must mask.
  always_comb begin
    calc_out = 8'hAA;
    case (calc_oper)
      3'b000: calc_out = {4'h0, calc_a} + {4'h0, calc_b};
      3'b001: calc_out = {4'h0, calc_a} - {4'h0, calc_b};
      3'b010: calc_out = {4'h0, calc_a} * {4'h0, calc_b};
      3'b011: calc_out = (calc_b == 4'h0) ? 8'hFF : {4'h0, calc_a / calc_b};
      3'b100: calc_out = (calc_b == 4'h0) ? 8'hFF : {4'h0, calc_a % calc_b};
      3'b101: calc_out = ~{4'h0, calc_a};
      default: calc_out = 8'hAA;
    endcase
    if (force_zero) calc_out = 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single command with rsp_ready high; accept edge counted as the first of the three.
  task automatic run_cmd(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic [7:0] exp_data, input logic exp_err);
    rsp_ready = 1'b1;
    cmd_a = a; cmd_b = b; cmd_oper = op; cmd_valid = 1'b1;
    check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check({tag, ".v_e0"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, ".v_e1"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, ".v_e2"}, 32'(rsp_valid), 32'd1);
    check({tag, ".data"}, 32'(rsp_data), 32'(exp_data));
    check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, ".oper"}, 32'(rsp_oper), 32'(op));
    check({tag, ".calc"}, 32'({calc_a, calc_b, calc_oper}), 32'({a, b, op}));
    tick();
    check({tag, ".v_clr"}, 32'(rsp_valid), 32'd0);
  endtask

  logic [3:0] va   [6] = '{4'd1, 4'd2, 4'd4, 4'd13, 4'd7, 4'd3};
  logic [3:0] vb   [6] = '{4'd2, 4'd7, 4'd5, 4'd4,  4'd0, 4'd1};
  logic [2:0] vop  [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
  logic [7:0] vexp [6] = '{8'h03, 8'hFB, 8'h14, 8'h03, 8'h00, 8'hFC};
  logic       verr [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int idx;
    int n;
    int stale;
    logic rdy;
    logic [7:0] hold_data;
    logic [2:0] hold_oper;

    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_oper = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst.cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp", 32'({rsp_data, rsp_err, rsp_oper}), 32'd0);
    check("rst.calc", 32'({calc_a, calc_b, calc_oper}), 32'd0);

    run_cmd("add", 4'd3, 4'd5, 3'b000, 8'h08, 1'b0);
    run_cmd("sub", 4'd3, 4'd5, 3'b001, 8'hFE, 1'b0);
    run_cmd("mul", 4'd15, 4'd15, 3'b010, 8'hE1, 1'b0);
    run_cmd("nota", 4'd3, 4'd0, 3'b101, 8'hFC, 1'b0);
    run_cmd("div0", 4'd9, 4'd0, 3'b011, 8'h00, 1'b1);
    run_cmd("mod", 4'd9, 4'd2, 3'b100, 8'h01, 1'b0);
    run_cmd("op110", 4'd9, 4'd2, 3'b110, 8'h00, 1'b1);
    run_cmd("op111", 4'd1, 4'd1, 3'b111, 8'h00, 1'b1);
    check("hold.calc", 32'({calc_a, calc_b, calc_oper}), 32'({4'd1, 4'd1, 3'b111}));

    // Backpressure: fill one in flight plus the whole queue.
    rsp_ready = 1'b0;
    idx = 0;
    cmd_a = va[0]; cmd_b = vb[0]; cmd_oper = vop[0]; cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      rdy = cmd_ready;
      tick();
      if (rdy) begin
        idx++;
        if (idx < 6) begin
          cmd_a = va[idx]; cmd_b = vb[idx]; cmd_oper = vop[idx];
        end
      end
    end
    cmd_valid = 1'b0;
    check("bp.accepts", 32'(idx), 32'd5);
    check("bp.full", 32'(cmd_ready), 32'd0);
    check("bp.valid", 32'(rsp_valid), 32'd1);
    hold_data = rsp_data;
    hold_oper = rsp_oper;
    repeat (3) tick();
    check("bp.stable_v", 32'(rsp_valid), 32'd1);
    check("bp.stable_d", 32'({rsp_data, rsp_oper}), 32'({hold_data, hold_oper}));

    rsp_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (rsp_valid) begin
        if (n < 5) begin
          check($sformatf("ord%0d.data", n), 32'(rsp_data), 32'(vexp[n]));
          check($sformatf("ord%0d.err", n), 32'(rsp_err), 32'(verr[n]));
          check($sformatf("ord%0d.oper", n), 32'(rsp_oper), 32'(vop[n]));
        end
        n++;
      end
      tick();
    end
    check("ord.count", 32'(n), 32'd5);
    check("ord.ready", 32'(cmd_ready), 32'd1);

`ifdef CALC_SEQ_CHECK_EN
    check("chk.clean", 32'(chk_mismatch), 32'd0);
`endif

    // Reset with a response pending and three queued.
    rsp_ready = 1'b0;
    idx = 0;
    cmd_a = va[idx]; cmd_b = vb[idx]; cmd_oper = vop[idx]; cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      rdy = cmd_ready;
      tick();
      if (rdy) begin
        idx++;
        cmd_a = va[idx]; cmd_b = vb[idx]; cmd_oper = vop[idx];
      end
    end
    cmd_valid = 1'b0;
    check("mid.pushed", 32'(idx), 32'd4);
    check("mid.valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid.rst_valid", 32'(rsp_valid), 32'd0);
    check("mid.rst_ready", 32'(cmd_ready), 32'd1);
    check("mid.rst_calc", 32'({calc_a, calc_b, calc_oper}), 32'd0);
    rsp_ready = 1'b1;
    stale = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (rsp_valid) stale++;
      tick();
    end
    check("mid.stale", 32'(stale), 32'd0);

    run_cmd("post", 4'd6, 4'd6, 3'b000, 8'h0C, 1'b0);

`ifdef CALC_SEQ_CHECK_EN
    check("chk.post", 32'(chk_mismatch), 32'd0);
    force_zero = 1'b1;
    run_cmd("forced", 4'd3, 4'd5, 3'b000, 8'h00, 1'b0);
    force_zero = 1'b0;
    check("chk.set", 32'(chk_mismatch), 32'd1);
    run_cmd("sticky", 4'd1, 4'd1, 3'b000, 8'h02, 1'b0);
    check("chk.sticky", 32'(chk_mismatch), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
